// File: rtl/tdm_pkg.sv
// Shared sizing, counter-width helper and FSM state type for the TDM demultiplexer.
package tdm_pkg;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TDM_W    = 8;
    localparam int TDM_N_CH = 4;
    localparam int BIT_CW   = cnt_w(TDM_W);
    localparam int CH_CW    = cnt_w(TDM_N_CH);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit-within-slot and slot-within-frame counters with wrap flags.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int W    = TDM_W,
    parameter int N_CH = TDM_N_CH,
    parameter int BW   = cnt_w(W),
    parameter int CW   = cnt_w(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load1,
    output logic [CW-1:0] ch_cnt,
    output logic          bit_wrap,
    output logic          frame_wrap
);

    logic [BW-1:0] bit_cnt;

    assign bit_wrap   = (bit_cnt == BW'(W - 1));
    assign frame_wrap = bit_wrap && (ch_cnt == CW'(N_CH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            ch_cnt  <= '0;
        end else if (load1) begin
            // The frame-sync bit itself is bit 0 of channel 0, so counting resumes at 1.
            bit_cnt <= BW'(1);
            ch_cnt  <= '0;
        end else if (en) begin
            if (bit_wrap) begin
                bit_cnt <= '0;
                ch_cnt  <= frame_wrap ? '0 : ch_cnt + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM frame receiver: shifts slot bits in, stages whole words, publishes a frame at once.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int W    = TDM_W,
    parameter int N_CH = TDM_N_CH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Din,
    input  logic         Din_valid,
    input  logic         Fs,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic         Y_valid,
    output logic [1:0]   Sel,
    output logic         Frame_err
);

    localparam int CW = cnt_w(N_CH);

    state_t              state;
    logic [W-1:0]        shreg;
    logic [W-1:0]        word_nxt;
    logic [3:0][W-1:0]   stage;
    logic [3:0][W-1:0]   stage_nxt;
    logic [CW-1:0]       ch_cnt;
    logic                bit_wrap;
    logic                frame_wrap;
    logic                start;
    logic                adv;

    assign start    = Din_valid && Fs;
    assign adv      = Din_valid && !Fs && (state == RECV);
    assign word_nxt = {shreg[W-2:0], Din};
    assign Sel      = 2'(ch_cnt);

    tdm_slot_counter #(.W(W), .N_CH(N_CH)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .en         (adv),
        .load1      (start),
        .ch_cnt     (ch_cnt),
        .bit_wrap   (bit_wrap),
        .frame_wrap (frame_wrap)
    );

    // The final slot is still in the shifter on the last bit, so outputs load from this view.
    always_comb begin
        stage_nxt = stage;
        if (bit_wrap)
            stage_nxt[ch_cnt] = word_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            stage     <= '0;
            Y0        <= '0;
            Y1        <= '0;
            Y2        <= '0;
            Y3        <= '0;
            Y_valid   <= 1'b0;
            Frame_err <= 1'b0;
        end else begin
            Y_valid   <= 1'b0;
            Frame_err <= 1'b0;
            if (start) begin
                shreg     <= W'(Din);
                state     <= RECV;
                Frame_err <= (state == RECV);
            end else if (adv) begin
                shreg <= word_nxt;
                if (bit_wrap)
                    stage <= stage_nxt;
                if (frame_wrap) begin
                    Y0      <= stage_nxt[0];
                    Y1      <= stage_nxt[1];
                    Y2      <= stage_nxt[2];
                    Y3      <= stage_nxt[3];
                    Y_valid <= 1'b1;
                    state   <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: framing, gaps, aborts, pre-sync noise and mid-frame reset.
module tb_tdm_demux;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Din = 1'b0;
    logic       Din_valid = 1'b0;
    logic       Fs = 1'b0;
    logic [7:0] Y0, Y1, Y2, Y3;
    logic       Y_valid;
    logic [1:0] Sel;
    logic       Frame_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int yv_cnt = 0;
    int yv_cyc = -1;
    int fe_cnt = 0;
    int both = 0;

    tdm_demux #(.W(8), .N_CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .Din       (Din),
        .Din_valid (Din_valid),
        .Fs        (Fs),
        .Y0        (Y0),
        .Y1        (Y1),
        .Y2        (Y2),
        .Y3        (Y3),
        .Y_valid   (Y_valid),
        .Sel       (Sel),
        .Frame_err (Frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic v, input logic f);
        @(negedge clk);
        Din = d;
        Din_valid = v;
        Fs = f;
        @(posedge clk);
        #1;
        cyc++;
        if (Y_valid) begin
            yv_cnt++;
            yv_cyc = cyc;
        end
        if (Frame_err) fe_cnt++;
        if (Y_valid && Frame_err) both++;
    endtask

    // Frame word packs Y0..Y3 MSB-first; bit k of the frame is fr[31-k], Fs on bit 0.
    task automatic send(input logic [31:0] fr, input int from, input int to, input bit gap);
        for (int k = from; k <= to; k++) begin
            if (gap) step(1'b0, 1'b0, 1'b1);
            step(fr[31-k], 1'b1, (k == 0));
        end
    endtask

    initial begin
        int s, y0, y1, fe0;

        // Reset with valid Fs asserted to show reset wins.
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk("rst_y", {Y0, Y1, Y2, Y3}, 32'h0);
        chk("rst_yvalid", 32'(Y_valid), 32'h0);
        chk("rst_ferr", 32'(Frame_err), 32'h0);
        chk("rst_sel", 32'(Sel), 32'h0);

        // Single continuous frame.
        s = cyc; y0 = yv_cnt;
        send(32'hA53CFF01, 0, 31, 1'b0);
        chk("f1_yvalid_cycle", 32'(yv_cyc - s), 32'd32);
        chk("f1_y", {Y0, Y1, Y2, Y3}, 32'hA53CFF01);
        step(1'b0, 1'b0, 1'b0);
        chk("f1_yvalid_pulses", 32'(yv_cnt - y0), 32'd1);
        chk("f1_yvalid_low", 32'(Y_valid), 32'h0);
        chk("f1_sel_idle", 32'(Sel), 32'h0);
        chk("f1_no_ferr", 32'(fe_cnt), 32'd0);

        // Back-to-back frames with no gap.
        y0 = yv_cnt;
        send(32'hA53CFF01, 0, 31, 1'b0);
        y1 = yv_cyc;
        send(32'h12345678, 0, 31, 1'b0);
        chk("b2b_spacing", 32'(yv_cyc - y1), 32'd32);
        chk("b2b_pulses", 32'(yv_cnt - y0), 32'd2);
        chk("b2b_y", {Y0, Y1, Y2, Y3}, 32'h12345678);

        // Valid low every other cycle, Fs high in the invalid cycles.
        s = cyc;
        send(32'hA53CFF01, 0, 31, 1'b1);
        chk("gap_yvalid_cycle", 32'(yv_cyc - s), 32'd64);
        chk("gap_y", {Y0, Y1, Y2, Y3}, 32'hA53CFF01);
        chk("gap_no_ferr", 32'(fe_cnt), 32'd0);

        // Frame sync re-asserted at bit 13.
        fe0 = fe_cnt; y0 = yv_cnt;
        send(32'h12345678, 0, 12, 1'b0);
        chk("abort_sel_mid", 32'(Sel), 32'd1);
        send(32'hC35A9669, 0, 0, 1'b0);
        chk("abort_ferr", 32'(Frame_err), 32'h1);
        chk("abort_y_held", {Y0, Y1, Y2, Y3}, 32'hA53CFF01);
        chk("abort_sel", 32'(Sel), 32'h0);
        send(32'hC35A9669, 1, 31, 1'b0);
        chk("abort_new_y", {Y0, Y1, Y2, Y3}, 32'hC35A9669);
        chk("abort_ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("abort_yvalid_pulses", 32'(yv_cnt - y0), 32'd1);

        // Noise bits before sync are dropped.
        y0 = yv_cnt;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("pre_sel", 32'(Sel), 32'h0);
        chk("pre_no_yvalid", 32'(yv_cnt - y0), 32'd0);
        send(32'h3CA501FF, 0, 31, 1'b0);
        chk("pre_y", {Y0, Y1, Y2, Y3}, 32'h3CA501FF);

        // Reset at bit 20, then a clean frame.
        fe0 = fe_cnt;
        send(32'h12345678, 0, 19, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk("mrst_y", {Y0, Y1, Y2, Y3}, 32'h0);
        chk("mrst_yvalid", 32'(Y_valid), 32'h0);
        chk("mrst_ferr", 32'(Frame_err), 32'h0);
        chk("mrst_sel", 32'(Sel), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        send(32'h0FF0AA55, 0, 31, 1'b0);
        chk("mrst_new_y", {Y0, Y1, Y2, Y3}, 32'h0FF0AA55);
        chk("mrst_no_ferr", 32'(fe_cnt - fe0), 32'd0);

        chk("never_both", 32'(both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
